pc_gen_unit: RTL and testbench

- Parametrised program-counter generation unit for the pipelined RISC-V core.
- Owns the architectural fetch PC register and selects the next PC from sequential, jump (pc+imm, rs1+imm) and conditional-branch sources.
- Buffers a redirect that arrives while fetch is stalled, implements a halt-address trap as a small FSM, and counts redirects for performance monitoring.
- Sits between the EX-stage branch/jump resolution logic and the IF stage. Drives the pipeline flush.

---
 rtl/pc_gen_unit.sv | 186 ++++++++++++++++++
 tb/tb_pc_gen_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_unit
// Purpose  : Program-counter generation for the pipelined RISC-V core.
//            Owns the architectural fetch PC. Each cycle it picks the next PC
//            from these sources:
//              - sequential (pc + INC)
//              - jump to pc+imm
//              - jump to rs1+imm
//              - a taken conditional branch
//              - a redirect buffered while fetch was stalled.
//            A small FSM parks the PC at HALT_ADDR. A saturating counter
//            tracks redirects for performance monitoring.
// Ports    : clk          - core clock
//            reset        - synchronous, active-high reset
//            stall        - hold the PC this cycle (hazard unit)
//            ex_valid     - qualifies the EX-stage jump/branch inputs
//            jump_sel     - 01: jump to pc_imm, 10: jump to rs1_imm
//            branch_taken - conditional branch resolved taken
//            pc_imm       - pc+imm target
//            rs1_imm      - rs1+imm target (bit 0 already cleared)
//            pc           - current fetch PC (registered)
//            flush        - kill younger instructions (combinational)
//            halted       - FSM is parked in HALT
//            pend_valid   - a redirect target is buffered
//            redirect_cnt - saturating redirect count
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen_unit #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter bit              HALT_EN   = 1'b1,
    parameter logic [XLEN-1:0] HALT_ADDR = XLEN'('h13c),
    parameter int              INC       = 4,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [1:0]       jump_sel,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  pc_imm,
    input  logic [XLEN-1:0]  rs1_imm,
    output logic [XLEN-1:0]  pc,
    output logic             flush,
    output logic             halted,
    output logic             pend_valid,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [XLEN-1:0] c_INC     = XLEN'(INC);
    localparam logic [1:0]      c_JMP_PC  = 2'b01;
    localparam logic [1:0]      c_JMP_RS1 = 2'b10;

    // FSM state encoding
    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_pend_pc;
    logic             r_pend_valid;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_redirect;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_pc_nxt;
    logic [XLEN-1:0]  w_pend_pc_nxt;
    logic             w_pend_valid_nxt;
    logic [0:0]       w_state_nxt;
    logic             w_cnt_sat;
    logic             w_at_halt;

    // ------------------------------------------------------------------
    // Redirect decode and target select.
    // The jump selectors outrank the branch. jump_sel==11 is treated as
    // "no jump", so a taken branch can still redirect in that case.
    // ------------------------------------------------------------------
    assign w_redirect = ex_valid &
                        ((jump_sel == c_JMP_PC) | (jump_sel == c_JMP_RS1) |
                         branch_taken);

    always_comb begin
        w_target = pc_imm;
        if (jump_sel == c_JMP_PC) begin
            w_target = pc_imm;
        end else if (jump_sel == c_JMP_RS1) begin
            w_target = rs1_imm;
        end else begin
            w_target = pc_imm;
        end
    end

    // Flush fires in the redirect cycle whatever the stall and FSM state
    // are. The younger instructions are wrong-path even when the new
    // target has to be buffered.
    assign flush = w_redirect & ~reset;

    assign w_at_halt = HALT_EN && (r_pc == HALT_ADDR);

    // ------------------------------------------------------------------
    // Next-state logic. The if/else chain encodes the priority order:
    // a live redirect, then stall, then the buffered redirect, then halt,
    // then sequential fetch.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_nxt         = r_pc;
        w_pend_pc_nxt    = r_pend_pc;
        w_pend_valid_nxt = r_pend_valid;
        w_state_nxt      = r_state;

        if (w_redirect && !stall) begin
            // A live redirect supersedes anything already buffered.
            w_pc_nxt         = w_target;
            w_pend_valid_nxt = 1'b0;
            w_state_nxt      = c_ST_RUN;
        end else if (w_redirect) begin
            // Fetch is frozen, so keep the target. The newest one wins.
            w_pend_pc_nxt    = w_target;
            w_pend_valid_nxt = 1'b1;
        end else if (stall) begin
            // Hold everything.
            w_pc_nxt = r_pc;
        end else if (r_pend_valid) begin
            w_pc_nxt         = r_pend_pc;
            w_pend_valid_nxt = 1'b0;
            w_state_nxt      = c_ST_RUN;
        end else if (r_state == c_ST_HALT) begin
            // Parked: wait for a redirect.
            w_pc_nxt = r_pc;
        end else if (w_at_halt) begin
            w_state_nxt = c_ST_HALT;
        end else begin
            w_pc_nxt = r_pc + c_INC;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_VEC;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
            r_state      <= c_ST_RUN;
        end else begin
            r_pc         <= w_pc_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_state      <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Redirect performance counter. Stalled redirects count too. The
    // counter sticks at all-ones so software never sees it wrap.
    // ------------------------------------------------------------------
    assign w_cnt_sat = &r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_redirect && !w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc           = r_pc;
    assign pend_valid   = r_pend_valid;
    assign redirect_cnt = r_cnt;

    generate
        if (HALT_EN) begin : g_halt_on
            assign halted = (r_state == c_ST_HALT);
        end else begin : g_halt_off
            assign halted = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen_unit
// Purpose  : Self-checking bench for pc_gen_unit.
//            Three instances share the same stimulus:
//              - the 64-bit default build
//              - a CNT_W=2 build, for counter saturation
//              - a 32-bit build with HALT_EN=0 and RESET_VEC=0xFFFFFFFC,
//                for PC wrap and the disabled halt trap.
//            The expected outputs of the main instance are queued as each
//            step is driven, then popped after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        ex_valid;
    logic [1:0]  jump_sel;
    logic        branch_taken;
    logic [63:0] pc_imm;
    logic [63:0] rs1_imm;

    logic [63:0] pc1;
    logic        flush1;
    logic        halted1;
    logic        pend1;
    logic [15:0] cnt1;

    logic [63:0] pc2;
    logic        flush2;
    logic        halted2;
    logic        pend2;
    logic [1:0]  cnt2;

    logic [31:0] pc3;
    logic        flush3;
    logic        halted3;
    logic        pend3;
    logic [15:0] cnt3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] pc;
        logic        pend;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];

    pc_gen_unit #(
        .XLEN(64), .RESET_VEC(64'h0), .HALT_EN(1'b1),
        .HALT_ADDR(64'h13c), .INC(4), .CNT_W(16)
    ) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .jump_sel(jump_sel), .branch_taken(branch_taken),
        .pc_imm(pc_imm), .rs1_imm(rs1_imm),
        .pc(pc1), .flush(flush1), .halted(halted1),
        .pend_valid(pend1), .redirect_cnt(cnt1)
    );

    pc_gen_unit #(
        .XLEN(64), .RESET_VEC(64'h0), .HALT_EN(1'b1),
        .HALT_ADDR(64'h13c), .INC(4), .CNT_W(2)
    ) u_dut_cnt2 (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .jump_sel(jump_sel), .branch_taken(branch_taken),
        .pc_imm(pc_imm), .rs1_imm(rs1_imm),
        .pc(pc2), .flush(flush2), .halted(halted2),
        .pend_valid(pend2), .redirect_cnt(cnt2)
    );

    pc_gen_unit #(
        .XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .HALT_EN(1'b0),
        .HALT_ADDR(32'h13c), .INC(4), .CNT_W(16)
    ) u_dut_x32 (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .jump_sel(jump_sel), .branch_taken(branch_taken),
        .pc_imm(pc_imm[31:0]), .rs1_imm(rs1_imm[31:0]),
        .pc(pc3), .flush(flush3), .halted(halted3),
        .pend_valid(pend3), .redirect_cnt(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic ev, input logic [1:0] js,
                         input logic bt, input logic [63:0] pi,
                         input logic [63:0] ri);
        stall        = s;
        ex_valid     = ev;
        jump_sel     = js;
        branch_taken = bt;
        pc_imm       = pi;
        rs1_imm      = ri;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
    endtask

    // Check the combinational flush for the driven inputs. Then queue the
    // expected post-edge state, clock once, and compare against the queue.
    task automatic cyc(input logic exp_flush, input logic [63:0] p,
                       input logic pv, input logic h, input logic [15:0] c);
        exp_t e;
        #1;
        chk("flush", {63'h0, flush1}, {63'h0, exp_flush});
        q.push_back('{pc: p, pend: pv, halted: h, cnt: c});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_underflow", 64'h1, 64'h0);
        end else begin
            e = q.pop_front();
            chk("pc", pc1, e.pc);
            chk("pend_valid", {63'h0, pend1}, {63'h0, e.pend});
            chk("halted", {63'h0, halted1}, {63'h0, e.halted});
            chk("redirect_cnt", {48'h0, cnt1}, {48'h0, e.cnt});
        end
    endtask

    initial begin
        // Reset. A redirect presented during reset must not flush.
        reset = 1'b1;
        drive(1'b0, 1'b1, 2'b01, 1'b0, 64'h500, 64'h0);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 16'd0);
        chk("x32_reset_pc", {32'h0, pc3}, 64'hFFFF_FFFC);
        chk("cnt2_reset", {62'h0, cnt2}, 64'h0);

        reset = 1'b0;
        idle();
        cyc(1'b0, 64'h4, 1'b0, 1'b0, 16'd0);
        chk("x32_wrap_pc", {32'h0, pc3}, 64'h0);
        cyc(1'b0, 64'h8, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 64'hc, 1'b0, 1'b0, 16'd0);
        for (int v = 16; v <= 32; v += 4)
            cyc(1'b0, 64'(v), 1'b0, 1'b0, 16'd0);

        // rs1+imm jump at pc=0x20
        drive(1'b0, 1'b1, 2'b10, 1'b0, 64'h999, 64'h400);
        cyc(1'b1, 64'h400, 1'b0, 1'b0, 16'd1);
        idle();
        cyc(1'b0, 64'h404, 1'b0, 1'b0, 16'd1);

        // Two redirects while stalled: the last one wins
        drive(1'b1, 1'b1, 2'b00, 1'b1, 64'h80, 64'h0);
        cyc(1'b1, 64'h404, 1'b1, 1'b0, 16'd2);
        drive(1'b1, 1'b1, 2'b01, 1'b0, 64'h100, 64'h0);
        cyc(1'b1, 64'h404, 1'b1, 1'b0, 16'd3);
        idle();
        cyc(1'b0, 64'h100, 1'b0, 1'b0, 16'd3);

        // Plain stall holds the PC
        drive(1'b1, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
        cyc(1'b0, 64'h100, 1'b0, 1'b0, 16'd3);
        idle();
        cyc(1'b0, 64'h104, 1'b0, 1'b0, 16'd3);

        // Target priority, and ex_valid gating
        drive(1'b0, 1'b1, 2'b01, 1'b1, 64'h40, 64'h90);
        cyc(1'b1, 64'h40, 1'b0, 1'b0, 16'd4);
        drive(1'b0, 1'b0, 2'b01, 1'b1, 64'h40, 64'h90);
        cyc(1'b0, 64'h44, 1'b0, 1'b0, 16'd4);
        drive(1'b0, 1'b1, 2'b10, 1'b1, 64'h40, 64'h90);
        cyc(1'b1, 64'h90, 1'b0, 1'b0, 16'd5);
        drive(1'b0, 1'b1, 2'b11, 1'b1, 64'h60, 64'h90);
        cyc(1'b1, 64'h60, 1'b0, 1'b0, 16'd6);
        drive(1'b0, 1'b1, 2'b11, 1'b0, 64'h60, 64'h90);
        cyc(1'b0, 64'h64, 1'b0, 1'b0, 16'd6);
        chk("cnt2_saturated", {62'h0, cnt2}, 64'h3);

        // Halt trap at 0x13c
        drive(1'b0, 1'b1, 2'b01, 1'b0, 64'h130, 64'h0);
        cyc(1'b1, 64'h130, 1'b0, 1'b0, 16'd7);
        idle();
        cyc(1'b0, 64'h134, 1'b0, 1'b0, 16'd7);
        cyc(1'b0, 64'h138, 1'b0, 1'b0, 16'd7);
        cyc(1'b0, 64'h13c, 1'b0, 1'b0, 16'd7);
        cyc(1'b0, 64'h13c, 1'b0, 1'b1, 16'd7);
        cyc(1'b0, 64'h13c, 1'b0, 1'b1, 16'd7);
        chk("x32_no_halt_pc", {32'h0, pc3}, 64'h144);
        chk("x32_halted", {63'h0, halted3}, 64'h0);

        // Direct redirect leaves HALT
        drive(1'b0, 1'b1, 2'b01, 1'b0, 64'h0, 64'h0);
        cyc(1'b1, 64'h0, 1'b0, 1'b0, 16'd8);

        // Re-enter HALT, then leave it through a buffered redirect
        drive(1'b0, 1'b1, 2'b01, 1'b0, 64'h138, 64'h0);
        cyc(1'b1, 64'h138, 1'b0, 1'b0, 16'd9);
        idle();
        cyc(1'b0, 64'h13c, 1'b0, 1'b0, 16'd9);
        cyc(1'b0, 64'h13c, 1'b0, 1'b1, 16'd9);
        drive(1'b1, 1'b1, 2'b01, 1'b0, 64'h200, 64'h0);
        cyc(1'b1, 64'h13c, 1'b1, 1'b1, 16'd10);
        idle();
        cyc(1'b0, 64'h200, 1'b0, 1'b0, 16'd10);
        cyc(1'b0, 64'h204, 1'b0, 1'b0, 16'd10);

        // A live redirect discards a buffered one
        drive(1'b1, 1'b1, 2'b01, 1'b0, 64'h300, 64'h0);
        cyc(1'b1, 64'h204, 1'b1, 1'b0, 16'd11);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 64'h500, 64'h0);
        cyc(1'b1, 64'h500, 1'b0, 1'b0, 16'd12);
        idle();
        cyc(1'b0, 64'h504, 1'b0, 1'b0, 16'd12);

        // Reset while a redirect is buffered
        drive(1'b1, 1'b1, 2'b01, 1'b0, 64'h600, 64'h0);
        cyc(1'b1, 64'h504, 1'b1, 1'b0, 16'd13);
        reset = 1'b1;
        drive(1'b1, 1'b1, 2'b01, 1'b0, 64'h700, 64'h0);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 16'd0);
        chk("x32_rereset_pc", {32'h0, pc3}, 64'hFFFF_FFFC);
        chk("cnt2_rereset", {62'h0, cnt2}, 64'h0);
        reset = 1'b0;
        idle();
        cyc(1'b0, 64'h4, 1'b0, 1'b0, 16'd0);
        chk("x32_rereset_wrap", {32'h0, pc3}, 64'h0);
        chk("queue_drained", 64'(q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
